// File: rtl/fifo_pkg.sv
// Shared pointer types and Gray/binary helpers for the async FIFO
// write-side and read-side pointer blocks.
package fifo_pkg;

    localparam int PKG_ADDRSIZE = 4;
    localparam int CODE_W = 32;

    typedef logic [PKG_ADDRSIZE:0] ptr_t;
    typedef logic [CODE_W-1:0] code_t;

    function automatic code_t bin2gray(input code_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and every bit above it.
    function automatic code_t gray2bin(input code_t g);
        code_t b;
        b = g;
        for (int i = 1; i < CODE_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchroniser carrying the Gray read pointer into w_clk.
// Synchronous active-high reset clears both stages.
module sync_r2w #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full flag, fill level and overflow for the async FIFO.
// Optional almost-full output under FIFO_ALMOST_FULL_EN.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 14
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_inc,
    input  logic [ADDRSIZE:0] r_ptr,
    output logic [ADDRSIZE:0] w_ptr,
    output logic [ADDRSIZE-1:0] w_addr,
    output logic              w_full,
`ifdef FIFO_ALMOST_FULL_EN
    output logic              w_almost_full,
`endif
    output logic [ADDRSIZE:0] w_level,
    output logic              w_overflow
);

    localparam int PW = ADDRSIZE + 1;

    if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDRSIZE)) begin : g_bad_thresh
        $error("AFULL_THRESH out of range");
    end

    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_bin_nxt;
    logic [PW-1:0] w_gray_nxt;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] rq2_bin;
    logic [PW-1:0] level_nxt;
    logic [PW-1:0] full_cmp;
    logic          accept;
    logic          full_nxt;

    sync_r2w #(
        .WIDTH(PW)
    ) u_sync (
        .clk(w_clk),
        .rst(w_rst),
        .d  (r_ptr),
        .q  (wq2_rptr)
    );

    always_comb begin
        accept     = w_inc & ~w_full;
        w_bin_nxt  = w_bin + PW'(accept);
        w_gray_nxt = PW'(bin2gray(CODE_W'(w_bin_nxt)));
        rq2_bin    = PW'(gray2bin(CODE_W'(wq2_rptr)));
        // Stale read pointer makes this an upper bound on the true fill.
        level_nxt  = w_bin_nxt - rq2_bin;
        full_cmp   = {~wq2_rptr[ADDRSIZE -: 2], wq2_rptr[ADDRSIZE-2:0]};
        full_nxt   = (w_gray_nxt == full_cmp);
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            w_bin      <= '0;
            w_ptr      <= '0;
            w_full     <= 1'b0;
            w_level    <= '0;
            w_overflow <= 1'b0;
        end else begin
            w_bin      <= w_bin_nxt;
            w_ptr      <= w_gray_nxt;
            w_full     <= full_nxt;
            w_level    <= level_nxt;
            w_overflow <= w_overflow | (w_inc & w_full);
        end
    end

    assign w_addr = w_bin[ADDRSIZE-1:0];

`ifdef FIFO_ALMOST_FULL_EN
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            w_almost_full <= 1'b0;
        end else begin
            w_almost_full <= (level_nxt >= PW'(AFULL_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl against a count-based model.
// Covers the almost-full output when FIFO_ALMOST_FULL_EN is defined.
module tb_wptr_full_ctrl;

    localparam int A   = 4;
    localparam int D   = 16;
    localparam int THR = 14;

    logic       w_clk = 1'b0;
    logic       w_rst;
    logic       w_inc;
    logic [4:0] r_ptr;
    logic [4:0] w_ptr;
    logic [3:0] w_addr;
    logic       w_full;
    logic [4:0] w_level;
    logic       w_overflow;
`ifdef FIFO_ALMOST_FULL_EN
    logic       w_almost_full;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: unbounded write/read counts; sync stages hold read counts.
    int m_wcnt, m_q1, m_q2, m_lvl;
    bit m_full, m_ovf, m_af;
    int rd_cnt, h1, h2;

    wptr_full_ctrl #(
        .ADDRSIZE    (A),
        .AFULL_THRESH(THR)
    ) dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .w_inc        (w_inc),
        .r_ptr        (r_ptr),
        .w_ptr        (w_ptr),
        .w_addr       (w_addr),
        .w_full       (w_full),
`ifdef FIFO_ALMOST_FULL_EN
        .w_almost_full(w_almost_full),
`endif
        .w_level      (w_level),
        .w_overflow   (w_overflow)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic inc, input int rd);
        int acc;
        logic [4:0] pp;
        w_rst = rst;
        w_inc = inc;
        r_ptr = gray(rd);
        pp = w_ptr;
        acc = 0;
        @(posedge w_clk);
        if (rst) begin
            m_wcnt = 0; m_q1 = 0; m_q2 = 0; m_lvl = 0;
            m_full = 0; m_ovf = 0; m_af = 0;
        end else begin
            acc = (inc && !m_full) ? 1 : 0;
            if (inc && m_full) m_ovf = 1;
            m_wcnt += acc;
            m_lvl = (m_wcnt - m_q2) % 32;
            m_full = (m_lvl == D);
            m_af = (m_lvl >= THR);
            m_q2 = m_q1;
            m_q1 = rd;
        end
        #1;
        chk("ptr", 32'(w_ptr), 32'(gray(m_wcnt)));
        chk("addr", 32'(w_addr), 32'(m_wcnt % D));
        chk("full", 32'(w_full), 32'(m_full));
        chk("level", 32'(w_level), 32'(m_lvl));
        chk("ovf", 32'(w_overflow), 32'(m_ovf));
`ifdef FIFO_ALMOST_FULL_EN
        chk("afull", 32'(w_almost_full), 32'(m_af));
`endif
        if (!rst) chk("gray_flip", 32'($countones(pp ^ w_ptr)), 32'(acc));
    endtask

    initial begin
        w_rst = 1'b1;
        w_inc = 1'b1;
        r_ptr = '0;
        rd_cnt = 0;

        // Reset with write request held high
        step(1, 1, 0);
        step(1, 1, 0);
        chk("rst_addr", 32'(w_addr), 32'd0);

        // Fill 16 with read pointer parked at 0
        for (int i = 0; i < D; i++) step(0, 1, 0);
        chk("fill_full", 32'(w_full), 32'd1);
        chk("fill_ptr", 32'(w_ptr), 32'b11000);
        chk("fill_addr", 32'(w_addr), 32'd0);
        chk("fill_lvl", 32'(w_level), 32'd16);

        // Writes while full are rejected and flagged
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        chk("ovf_ptr", 32'(w_ptr), 32'b11000);
        chk("ovf_set", 32'(w_overflow), 32'd1);

        // One read: full drops two edges later
        step(0, 0, 1);
        chk("rd_n", 32'(w_full), 32'd1);
        step(0, 0, 1);
        chk("rd_n1", 32'(w_full), 32'd1);
        step(0, 0, 1);
        chk("rd_n2", 32'(w_full), 32'd0);
        chk("rd_lvl", 32'(w_level), 32'd15);
        chk("ovf_sticky", 32'(w_overflow), 32'd1);

        // Almost-full threshold crossing
        step(1, 0, 0);
        for (int i = 0; i < 13; i++) step(0, 1, 0);
`ifdef FIFO_ALMOST_FULL_EN
        chk("af_13", 32'(w_almost_full), 32'd0);
`endif
        step(0, 1, 0);
`ifdef FIFO_ALMOST_FULL_EN
        chk("af_14", 32'(w_almost_full), 32'd1);
`endif

        // 40 writes, reader trailing by two cycles, across the wrap
        step(1, 0, 0);
        h1 = 0;
        h2 = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, h2);
            h2 = h1;
            h1 = m_wcnt;
        end
        chk("wrap_cnt", 32'(w_ptr), 32'(gray(40)));
        chk("wrap_ovf", 32'(w_overflow), 32'd0);

        // Random writes and reads with occasional reset
        step(1, 0, 0);
        rd_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rd_cnt = 0;
                step(1, 1'($urandom_range(0, 1)), 0);
            end else begin
                if (rd_cnt < m_wcnt && $urandom_range(0, 2) == 0) rd_cnt++;
                step(0, 1'($urandom_range(0, 3) != 0), rd_cnt);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and full-flag controller for the async FIFO. It sits directly upstream of the dual-port FIFO memory in the `w_clk` domain and drives the memory's `w_addr` and `w_full` inputs. It takes the Gray-coded read pointer from the read domain and synchronises it into `w_clk`. It produces a registered full flag, a write-domain fill level, an optional almost-full flag and a sticky overflow error.

## Interface
- `ADDRSIZE`, default 4: memory address width; depth is 2^ADDRSIZE words.
- `AFULL_THRESH`, default 14: fill level at or above which `w_almost_full` asserts; legal range 1..2^ADDRSIZE.

Ports:
- `w_clk`  in  1  write-domain clock; only clock of the block.
- `w_rst`  in  1  reset; synchronous to `w_clk`, active-high.
- `w_inc`  in  1  write request; the same strobe that drives the memory's `w_en`.
- `r_ptr`  in  ADDRSIZE+1  Gray read pointer from the read domain; asynchronous to `w_clk`.
- `w_ptr`  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
- `w_addr`  out  ADDRSIZE  registered binary write address to the memory.
- `w_full`  out  1  registered full flag to the memory and the producer.
- `w_almost_full`  out  1  registered; present only under the macro.
- `w_level`  out  ADDRSIZE+1  registered fill level, range 0..2^ADDRSIZE.
- `w_overflow`  out  1  sticky; a write was attempted while full.

## Operation
- Internal binary counter `w_bin`, ADDRSIZE+1 bits.
  - `accept = w_inc & ~w_full`.
  - `w_bin_nxt = w_bin + accept`, modulo 2^(ADDRSIZE+1).
  - `w_gray_nxt = (w_bin_nxt >> 1) ^ w_bin_nxt`.
- Register outputs: `w_ptr <= w_gray_nxt`; `w_addr = w_bin[ADDRSIZE-1:0]`.
  - `w_addr` always equals the slot the memory writes on the current edge.
- Synchroniser: `r_ptr` passes through two flops to give `wq2_rptr`.
- Full: `w_full <= (w_gray_nxt == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]})`.
- Level: `w_level <= w_bin_nxt - gray2bin(wq2_rptr)`, modulo 2^(ADDRSIZE+1).
  - The value is pessimistic: it is never below the true fill.
- Overflow: `w_overflow <= w_overflow | (w_inc & w_full)`. Only `w_rst` clears it.
- A rejected write (`w_inc` while full) leaves `w_bin`, `w_ptr` and `w_addr` unchanged.
- Wrap-around: `w_bin` rolls from 2^(ADDRSIZE+1)-1 to 0. The Gray pointer changes exactly one bit per accepted write.
- Reset state: `w_ptr`, `w_addr`, `w_level`, `w_overflow`, `w_almost_full`, `w_full` and both synchroniser flops are all 0.
  - Reset mid-operation drops in-flight data.
  - The read domain must be reset in the same window; this is a system-level rule.

## Timing
- Accepted write at edge k: `w_bin`, `w_ptr`, `w_addr`, `w_level` and `w_full` update at edge k.
  - The write that fills the last slot asserts `w_full` at that same edge.
  - No write can be accepted at edge k+1.
- `r_ptr` stable before edge n: captured in flop 1 at n, in flop 2 (`wq2_rptr`) at n+1. `w_full`, `w_level` and `w_almost_full` reflect it at edge n+2.
  - `w_full` deassertion is therefore delayed 2–3 `w_clk` cycles after the read.
- A read and a write on the same edge: the write is evaluated against the stale `wq2_rptr`. The full decision is conservative, never unsafe.
- Reset wins over `w_inc` on the same edge.
- Throughput: one write per cycle while not full. Added latency from `w_inc` to `w_addr` advance is 0 cycles.

## Configuration
- Macro `FIFO_ALMOST_FULL_EN`.
- Defined: the `w_almost_full` port exists and is registered as `w_almost_full <= (level_nxt >= AFULL_THRESH)`. It resets to 0 and is updated on the same edge as `w_level`.
- Undefined: the port and its logic are absent and `AFULL_THRESH` is ignored. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg`:
  - typedef `ptr_t` (ADDRSIZE+1 bits).
  - functions `bin2gray` and `gray2bin`.
  - The read-side pointer block uses the same package.
- Sub-module `sync_r2w`: a parameterised two-flop synchroniser with synchronous active-high reset. It clears to 0 on `w_rst`.

## Test plan
1. Assert `w_rst` for 2 cycles while `w_inc`=1 → all outputs 0 and `w_addr` stays 0.
2. Hold `r_ptr`=0 and make 16 consecutive writes → `w_full`=1 at the 16th accept edge, `w_addr`=0 (wrapped), `w_ptr`=5'b11000, `w_level`=16.
3. While full, hold `w_inc`=1 for 3 cycles → `w_addr`/`w_ptr` unchanged, `w_overflow`=1 and it stays 1 until reset.
4. While full, set `r_ptr`=5'b00001 before edge n → `w_full` is 1 at n and n+1 and 0 after n+2; `w_level`=15.
5. With the macro defined, fill to level 13, then 14 → `w_almost_full` goes 0 then 1 on the 14th accept edge. With the macro undefined, the port is absent and the build is clean.
6. Make 40 writes with `r_ptr` tracking 2 cycles behind → each `w_ptr` step flips exactly one bit, the pointer wraps 31→0, and no overflow occurs.
